// File: rtl/command_credit_arbiter_if.sv
// Bundles the requester, PSL command and PSL response signals of the
// command credit arbiter.
//   req_*  : two requesters (bit/index 0 = read engine, 1 = write engine)
//   cmd_*  : registered PSL command output with odd parity
//   rsp_*  : PSL response tag in, owner route out
// modport master : arbiter side; modport slave : requester/PSL side.
interface command_credit_arbiter_if;
  logic [1:0]        req_valid;
  logic [1:0][12:0]  req_command;
  logic [1:0][63:0]  req_address;
  logic [1:0][11:0]  req_size;
  logic [1:0]        req_ready;
  logic [7:0]        req_tag;
  logic              cmd_valid;
  logic [7:0]        cmd_tag;
  logic              cmd_tag_parity;
  logic [12:0]       cmd_command;
  logic              cmd_command_parity;
  logic [63:0]       cmd_address;
  logic              cmd_address_parity;
  logic [11:0]       cmd_size;
  logic              rsp_valid;
  logic [7:0]        rsp_tag;
  logic [1:0]        rsp_route;

  modport master (
    input  req_valid, req_command, req_address, req_size, rsp_valid, rsp_tag,
    output req_ready, req_tag, cmd_valid, cmd_tag, cmd_tag_parity, cmd_command,
           cmd_command_parity, cmd_address, cmd_address_parity, cmd_size, rsp_route
  );

  modport slave (
    output req_valid, req_command, req_address, req_size, rsp_valid, rsp_tag,
    input  req_ready, req_tag, cmd_valid, cmd_tag, cmd_tag_parity, cmd_command,
           cmd_command_parity, cmd_address, cmd_address_parity, cmd_size, rsp_route
  );
endinterface

// File: rtl/command_credit_arbiter.sv
// Round-robin arbiter issuing PSL commands from two requesters, bounded by
// PSL command credits (croom, captured once per job) and a pool of
// TAG_COUNT tags. Responses free tags and return credits in every state.
//   clock, rstn : rising-edge clock, synchronous active-low reset
//   enabled     : job running
//   croom       : command room loaded into the credit counter in LOAD
//   bus         : requester handshake, PSL command out, PSL response in
//   outstanding : number of tags in flight
//   tag_error   : sticky, response seen for a tag not in flight
module command_credit_arbiter #(
  parameter int TAG_COUNT = 16
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      enabled,
  input  logic [7:0]                croom,
  command_credit_arbiter_if.master  bus,
  output logic [5:0]                outstanding,
  output logic                      tag_error
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             credits, credit_lim;
  logic [TAG_COUNT-1:0]   busy, owner;
  logic                   ptr;
  logic                   any_free;
  logic [4:0]             free_tag;
  logic                   grant, gidx;
  logic                   rsp_hit, rsp_own;

  // Lowest-numbered free tag: scan downward so the last hit wins.
  always_comb begin
    any_free = 1'b0;
    free_tag = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        free_tag = 5'(i);
      end
    end
  end

  // Out-of-range tags never match, so they fall through as misses.
  always_comb begin
    rsp_hit = 1'b0;
    rsp_own = 1'b0;
    for (int i = 0; i < TAG_COUNT; i++) begin
      if (bus.rsp_tag == 8'(i)) begin
        rsp_hit = bus.rsp_valid & busy[i];
        rsp_own = owner[i];
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < TAG_COUNT; i++) outstanding = outstanding + 6'(busy[i]);
  end

  assign bus.rsp_route = rsp_hit ? (rsp_own ? 2'b10 : 2'b01) : 2'b00;

  // Pointer only matters when both request; a lone requester always wins.
  assign grant         = (state == RUN) && (credits != 8'd0) && any_free && (|bus.req_valid);
  assign gidx          = (&bus.req_valid) ? ptr : bus.req_valid[1];
  assign bus.req_ready = grant ? (gidx ? 2'b10 : 2'b01) : 2'b00;
  assign bus.req_tag   = grant ? {3'b000, free_tag} : 8'd0;

  always_ff @(posedge clock) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enabled) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (!enabled) state_nxt = DRAIN;
      DRAIN:   if (enabled) state_nxt = RUN;
               else if (outstanding == 6'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Credits are returned only for real responses and capped at the loaded
  // room so a stray response can never inflate them.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      credits    <= '0;
      credit_lim <= '0;
    end else if (state == LOAD) begin
      credits    <= croom;
      credit_lim <= croom;
    end else if (grant && !rsp_hit) begin
      credits <= credits - 8'd1;
    end else if (rsp_hit && !grant && credits != credit_lim) begin
      credits <= credits + 8'd1;
    end
  end

  // A responding tag is busy, so it can never equal free_tag this cycle.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      busy      <= '0;
      owner     <= '0;
      ptr       <= 1'b0;
      tag_error <= 1'b0;
    end else begin
      for (int i = 0; i < TAG_COUNT; i++) begin
        if (grant && free_tag == 5'(i)) begin
          busy[i]  <= 1'b1;
          owner[i] <= gidx;
        end else if (rsp_hit && bus.rsp_tag == 8'(i)) begin
          busy[i]  <= 1'b0;
        end
      end
      if (grant) ptr <= ~gidx;
      if (bus.rsp_valid && !rsp_hit) tag_error <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      bus.cmd_valid          <= 1'b0;
      bus.cmd_tag            <= '0;
      bus.cmd_tag_parity     <= 1'b0;
      bus.cmd_command        <= '0;
      bus.cmd_command_parity <= 1'b0;
      bus.cmd_address        <= '0;
      bus.cmd_address_parity <= 1'b0;
      bus.cmd_size           <= '0;
    end else begin
      bus.cmd_valid <= grant;
      if (grant) begin
        bus.cmd_tag            <= {3'b000, free_tag};
        bus.cmd_tag_parity     <= ~^{3'b000, free_tag};
        bus.cmd_command        <= bus.req_command[gidx];
        bus.cmd_command_parity <= ~^bus.req_command[gidx];
        bus.cmd_address        <= bus.req_address[gidx];
        bus.cmd_address_parity <= ~^bus.req_address[gidx];
        bus.cmd_size           <= bus.req_size[gidx];
      end
    end
  end

endmodule
